// File: rtl/tile_seq_ctrl.sv
// rtl/tile_seq_ctrl.sv - job sequencer for one systolic tile: operand feed, flush, capture, result handshake
module tile_seq_ctrl #(
  parameter int AK_BW     = 20,
  parameter int COLS      = 5,
  parameter int ROWS      = 5,
  parameter int K_W       = 8,
  parameter int FLUSH_CYC = ROWS + COLS - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_layer,
  input  logic [K_W-1:0]        i_k_len,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_rd_req,
  input  logic                  i_rd_vld,
  output logic                  o_zero_in,
  output logic                  o_en_tf,
  output logic [1:0]            o_cal_state,
  output logic [2:0]            o_layer_state,
  input  logic [AK_BW*COLS-1:0] i_acc_kernel,
  output logic [AK_BW*COLS-1:0] o_res,
  output logic                  o_res_vld,
  input  logic                  i_res_rdy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYC - 1);

  localparam logic [1:0] CAL_IDLE  = 2'd0;
  localparam logic [1:0] CAL_CALC  = 2'd1;
  localparam logic [1:0] CAL_FLUSH = 2'd2;
  localparam logic [1:0] CAL_STORE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_STORE,
    S_OUT
  } state_t;

  state_t                  state_q, state_d;
  logic [K_W-1:0]          feed_cnt_q, feed_cnt_d;
  logic [K_W-1:0]          k_len_q, k_len_d;
  logic [FC_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic [2:0]              layer_q, layer_d;
  logic [AK_BW*COLS-1:0]   res_q, res_d;
  logic                    err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      feed_cnt_q  <= '0;
      k_len_q     <= '0;
      flush_cnt_q <= '0;
      layer_q     <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      feed_cnt_q  <= feed_cnt_d;
      k_len_q     <= k_len_d;
      flush_cnt_q <= flush_cnt_d;
      layer_q     <= layer_d;
      res_q       <= res_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    feed_cnt_d  = feed_cnt_q;
    k_len_d     = k_len_q;
    flush_cnt_d = flush_cnt_q;
    layer_d     = layer_q;
    res_d       = res_q;
    err_d       = 1'b0;
    o_rd_req    = 1'b0;
    o_zero_in   = 1'b0;
    o_en_tf     = 1'b0;
    o_cal_state = CAL_IDLE;
    o_res_vld   = 1'b0;
    o_done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_k_len == '0) begin
            err_d = 1'b1;
          end else begin
            layer_d    = i_layer;
            k_len_d    = i_k_len;
            feed_cnt_d = '0;
            state_d    = S_FEED;
          end
        end
      end
      S_FEED: begin
        o_rd_req    = 1'b1;
        o_cal_state = CAL_CALC;
        // The tile only steps on cycles that actually carry operand data.
        o_en_tf     = i_rd_vld;
        if (i_rd_vld) begin
          if (feed_cnt_q == k_len_q - K_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
          end else begin
            feed_cnt_d = feed_cnt_q + K_W'(1);
          end
        end
      end
      S_FLUSH: begin
        o_zero_in   = 1'b1;
        o_en_tf     = 1'b1;
        o_cal_state = CAL_FLUSH;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_STORE;
        end else begin
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
      end
      S_STORE: begin
        o_en_tf     = 1'b1;
        o_cal_state = CAL_STORE;
        res_d       = i_acc_kernel;
        state_d     = S_OUT;
      end
      S_OUT: begin
        o_res_vld = 1'b1;
        if (i_res_rdy) begin
          o_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition, including a result handshake this cycle.
    if (i_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      res_d   = res_q;
      o_done  = 1'b0;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_layer_state = layer_q;
  assign o_res         = res_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// tb/tb_tile_seq_ctrl.sv - self-checking bench for tile_seq_ctrl with a phase-level job model
module tb_tile_seq_ctrl;
  localparam int AK_BW = 20;
  localparam int COLS = 5;
  localparam int K_W = 8;
  localparam int FLUSH_CYC = 9;
  localparam int RW = AK_BW * COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [2:0]    i_layer = '0;
  logic [K_W-1:0] i_k_len = '0;
  logic          i_abort = 1'b0;
  logic          o_busy;
  logic          o_rd_req;
  logic          i_rd_vld = 1'b0;
  logic          o_zero_in;
  logic          o_en_tf;
  logic [1:0]    o_cal_state;
  logic [2:0]    o_layer_state;
  logic [RW-1:0] i_acc_kernel = '0;
  logic [RW-1:0] o_res;
  logic          o_res_vld;
  logic          i_res_rdy = 1'b0;
  logic          o_done;
  logic          o_err;

  int n_assert = 0;
  int n_fail = 0;
  logic [2:0] last_layer = 3'd0;

  tile_seq_ctrl #(
    .AK_BW(AK_BW), .COLS(COLS), .ROWS(5), .K_W(K_W), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_layer(i_layer), .i_k_len(i_k_len),
    .i_abort(i_abort), .o_busy(o_busy), .o_rd_req(o_rd_req), .i_rd_vld(i_rd_vld),
    .o_zero_in(o_zero_in), .o_en_tf(o_en_tf), .o_cal_state(o_cal_state),
    .o_layer_state(o_layer_state), .i_acc_kernel(i_acc_kernel), .o_res(o_res),
    .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs_ctrl();
    return {o_layer_state, o_busy, o_rd_req, o_en_tf, o_zero_in, o_cal_state, o_res_vld, o_done, o_err};
  endfunction

  function automatic logic [11:0] ex(input logic [2:0] ly, input logic busy, input logic rd,
                                     input logic en, input logic zero, input logic [1:0] cal,
                                     input logic vld, input logic done, input logic err);
    return {ly, busy, rd, en, zero, cal, vld, done, err};
  endfunction

  function automatic logic [RW-1:0] rand_res();
    return RW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic chk_ctrl(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (layer busy rd en zero cal vld done err)", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One job seen as phases: start, K accepted vectors, FLUSH_CYC flush, one store, result handshake.
  task automatic run_job(input logic [2:0] ly, input logic [7:0] k, input logic [15:0] pat,
                         input int pat_len, input int vld_pct, input int rdy_wait,
                         input bit busy_starts, input int abort_flush, input bit abort_out);
    int acc_n;
    int fc;
    logic v;
    logic [RW-1:0] cap;

    @(negedge clk);
    i_start = 1'b1; i_layer = ly; i_k_len = k; i_rd_vld = 1'b0; i_res_rdy = 1'b0; i_abort = 1'b0;
    #1 chk_ctrl("start_idle", obs_ctrl(),
                ex(last_layer, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    last_layer = ly;

    acc_n = 0;
    fc = 0;
    while (acc_n < int'(k) && fc < 4 * int'(k) + 50) begin
      @(negedge clk);
      i_start = busy_starts ? 1'($urandom_range(1)) : 1'b0;
      i_layer = 3'($urandom_range(7));
      i_k_len = 8'($urandom_range(255));
      v = (fc < pat_len) ? pat[fc] : 1'($urandom_range(99) < vld_pct);
      i_rd_vld = v;
      #1 chk_ctrl("feed", obs_ctrl(), ex(ly, 1'b1, 1'b1, v, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0));
      acc_n += int'(v);
      fc++;
    end
    chk_int("feed_accepted", acc_n, int'(k));
    if (vld_pct == 100 && pat_len == 0) chk_int("feed_cycles", fc, int'(k));

    for (int i = 0; i < FLUSH_CYC; i++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_rd_vld = 1'($urandom_range(1));
      i_abort = (i == abort_flush);
      #1 chk_ctrl("flush", obs_ctrl(), ex(ly, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0));
      if (i == abort_flush) begin
        @(negedge clk);
        i_abort = 1'b0; i_rd_vld = 1'b0;
        #1 chk_ctrl("abort_flush_idle", obs_ctrl(),
                    ex(ly, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        return;
      end
    end

    @(negedge clk);
    cap = rand_res();
    i_acc_kernel = cap; i_rd_vld = 1'b0;
    #1 chk_ctrl("store", obs_ctrl(), ex(ly, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0));

    for (int w = 0; w < rdy_wait; w++) begin
      @(negedge clk);
      i_acc_kernel = rand_res(); i_res_rdy = 1'b0;
      #1 chk_ctrl("out_wait", obs_ctrl(), ex(ly, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
      chk_res("out_hold", o_res, cap);
    end

    @(negedge clk);
    i_acc_kernel = rand_res(); i_res_rdy = 1'b1; i_abort = abort_out;
    #1 chk_ctrl("out_hs", obs_ctrl(), ex(ly, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, !abort_out, 1'b0));
    chk_res("out_res", o_res, cap);

    @(negedge clk);
    i_res_rdy = 1'b0; i_abort = 1'b0;
    #1 chk_ctrl("post_idle", obs_ctrl(), ex(ly, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    chk_res("res_held", o_res, cap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk_ctrl("reset_ctrl", obs_ctrl(), 12'd0);
    chk_res("reset_res", o_res, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(3'd3, 8'd4, 16'd0, 0, 100, 0, 1'b0, -1, 1'b0);
    run_job(3'd1, 8'd3, 16'b101001, 6, 100, 0, 1'b0, -1, 1'b0);
    run_job(3'd6, 8'd2, 16'd0, 0, 100, 5, 1'b0, -1, 1'b0);

    @(negedge clk);
    i_start = 1'b1; i_k_len = 8'd0; i_layer = 3'd2;
    #1 chk_ctrl("zlen_start", obs_ctrl(), ex(last_layer, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    i_start = 1'b0;
    #1 chk_ctrl("zlen_err", obs_ctrl(), ex(last_layer, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    #1 chk_ctrl("zlen_after", obs_ctrl(), ex(last_layer, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));

    run_job(3'd2, 8'd2, 16'd0, 0, 100, 0, 1'b0, 4, 1'b0);
    run_job(3'd4, 8'd1, 16'd0, 0, 100, 0, 1'b0, -1, 1'b0);
    run_job(3'd7, 8'd3, 16'd0, 0, 100, 1, 1'b0, -1, 1'b1);

    @(negedge clk);
    i_start = 1'b1; i_layer = 3'd5; i_k_len = 8'd10;
    #1 chk_ctrl("rst_job_start", obs_ctrl(), ex(last_layer, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      i_start = 1'b0; i_rd_vld = 1'b1;
      #1 chk_ctrl("rst_job_feed", obs_ctrl(), ex(3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0));
    end
    #1 rst_n = 1'b0;
    #1 chk_ctrl("rst_mid_ctrl", obs_ctrl(), 12'd0);
    chk_res("rst_mid_res", o_res, '0);
    last_layer = 3'd0;
    @(negedge clk);
    i_rd_vld = 1'b0;
    rst_n = 1'b1;

    run_job(3'd5, 8'd255, 16'd0, 0, 80, 1, 1'b1, -1, 1'b0);

    for (int j = 0; j < 6; j++) begin
      run_job(3'($urandom_range(7)), 8'($urandom_range(20, 1)), 16'd0, 0,
              $urandom_range(100, 30), $urandom_range(3), 1'($urandom_range(1)), -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
